// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: per-digit patterns in, muxed segment/anode pins out.
// i_brightness exists only when SEG7_SCAN_BRIGHTNESS_EN is defined.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_7SEGMENTS = 8
);
  logic [0:NUM_7SEGMENTS-1][6:0] i_hex;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [3:0]                    i_brightness;
`endif
  logic [6:0]                    o_seg;
  logic [NUM_7SEGMENTS-1:0]      o_an;

`ifdef SEG7_SCAN_BRIGHTNESS_EN
  modport master (output i_hex, output i_brightness, input o_seg, input o_an);
  modport slave  (input i_hex, input i_brightness, output o_seg, output o_an);
`else
  modport master (output i_hex, input o_seg, input o_an);
  modport slave  (input i_hex, output o_seg, output o_an);
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with dead-time blanking between digits.
// Optional PWM brightness when SEG7_SCAN_BRIGHTNESS_EN is defined.
module seg7_scan_driver #(
  parameter int unsigned NUM_7SEGMENTS  = 8,
  parameter int unsigned SLOT_CYCLES    = 1000,
  parameter int unsigned DEAD_CYCLES    = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  seg7_scan_driver_if.slave    bus
);

  localparam int unsigned SW = $clog2(SLOT_CYCLES);
  localparam int unsigned IW = $clog2(NUM_7SEGMENTS);

  localparam logic [6:0]               SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_7SEGMENTS-1:0] AN_OFF  = {NUM_7SEGMENTS{AN_ACTIVE_LOW}};

  typedef enum logic {BLANK, ON} state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [6:0]               pat_q, pat_d;
  logic [6:0]               seg_q, seg_d;
  logic [NUM_7SEGMENTS-1:0] an_q, an_d;
  logic [NUM_7SEGMENTS-1:0] an_onehot;
  logic                     slot_wrap;
  logic                     last_blank;
  logic                     lit;

`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm_q, pwm_d;
  logic [3:0] bright_q, bright_d;
`endif

  always_comb begin
    slot_wrap  = (slot_cnt_q == SW'(SLOT_CYCLES - 1));
    last_blank = (slot_cnt_q == SW'(DEAD_CYCLES - 1));

    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SW'(1);

    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IW'(NUM_7SEGMENTS - 1)) ? '0 : idx_q + IW'(1);
    end

    state_d = state_q;
    case (state_q)
      BLANK:   if (last_blank) state_d = ON;
      ON:      if (slot_wrap)  state_d = BLANK;
      default: state_d = BLANK;
    endcase

    // Pattern is captured once per slot so mid-slot input changes wait for the next visit
    pat_d = last_blank ? bus.i_hex[idx_q] : pat_q;

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    bright_d = last_blank ? bus.i_brightness : bright_q;
    pwm_d    = pwm_q;
    if (state_q == BLANK && last_blank) begin
      pwm_d = '0;
    end else if (state_q == ON) begin
      pwm_d = pwm_q + 4'd1;
    end
    lit = (state_q == ON) && ((bright_q == 4'hF) || (pwm_q < bright_q));
`else
    lit = (state_q == ON);
`endif

    an_onehot        = '0;
    an_onehot[idx_q] = 1'b1;

    an_d  = lit ? (AN_ACTIVE_LOW ? ~an_onehot : an_onehot) : AN_OFF;
    seg_d = lit ? (SEG_ACTIVE_LOW ? pat_q : ~pat_q) : SEG_OFF;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= BLANK;
      slot_cnt_q <= '0;
      idx_q      <= '0;
      pat_q      <= '1;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      pwm_q      <= '0;
      bright_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      pat_q      <= pat_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      pwm_q      <= pwm_d;
      bright_q   <= bright_d;
`endif
    end
  end

  assign bus.o_seg = seg_q;
  assign bus.o_an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM=4, SLOT=20, DEAD=4) with a per-cycle scoreboard.
module tb_seg7_scan_driver;

  localparam int unsigned NUM  = 4;
  localparam int unsigned SLOT = 20;
  localparam int unsigned DEAD = 4;
  localparam int unsigned ON_LEN = SLOT - DEAD;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic clk;
  logic n_rst;
  int   errors;
  int   checks;

  seg7_scan_driver_if #(.NUM_7SEGMENTS(NUM)) bus ();

  seg7_scan_driver #(
    .NUM_7SEGMENTS (NUM),
    .SLOT_CYCLES   (SLOT),
    .DEAD_CYCLES   (DEAD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: after edge e (counted from reset release) digit ((e-5)/20)%4 is lit
  // for r=(e-5)%20 in 0..15, using the pattern sampled at the edge before it lit.
  function automatic exp_t expect_out(int e, logic [6:0] pat, logic [3:0] b);
    exp_t x;
    int   r;
    int   d;
    x.an  = 4'hF;
    x.seg = 7'h7F;
    if (e >= int'(DEAD + 1)) begin
      r = (e - int'(DEAD + 1)) % int'(SLOT);
      d = ((e - int'(DEAD + 1)) / int'(SLOT)) % int'(NUM);
      if (r < int'(ON_LEN) && (b == 4'hF || r < int'(b))) begin
        x.an  = 4'hF & ~(4'b0001 << d);
        x.seg = pat;
      end
    end
    return x;
  endfunction

  exp_t       exp_q[$];
  int         e_q;
  logic [6:0] lat_q;
  logic [3:0] b_q;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      e_q   <= 0;
      lat_q <= 7'h7F;
      b_q   <= 4'hF;
      exp_q.delete();
    end else begin
      exp_q.push_back(expect_out(e_q + 1, lat_q, b_q));
      e_q <= e_q + 1;
      if ((e_q + 1) >= int'(DEAD) && ((e_q + 1 - int'(DEAD)) % int'(SLOT)) == 0) begin
        lat_q <= bus.i_hex[((e_q + 1 - int'(DEAD)) / int'(SLOT)) % int'(NUM)];
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        b_q   <= bus.i_brightness;
`else
        b_q   <= 4'hF;
`endif
      end
    end
  end

  task automatic check(string tag, logic [7:0] obs, logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    exp_t x;
    @(negedge clk);
    if (n_rst) begin
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("scan_an",  {4'h0, bus.o_an}, {4'h0, x.an});
        check("scan_seg", {1'b0, bus.o_seg}, {1'b0, x.seg});
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  // Advance until digit d is a few cycles into its lit phase; expiry counts as a failure.
  task automatic wait_mid_on(int d, string tag);
    int guard;
    guard = 0;
    while (!(e_q >= int'(DEAD + 1) && ((e_q - int'(DEAD + 1)) % int'(SLOT)) == 8 &&
             (((e_q - int'(DEAD + 1)) / int'(SLOT)) % int'(NUM)) == d) && guard < 400) begin
      step();
      guard++;
    end
    check(tag, {7'h0, guard < 400}, 8'h01);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    n_rst  = 1'b0;
    bus.i_hex = '0;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    bus.i_brightness = 4'hF;
`endif

    repeat (3) @(negedge clk);
    check("reset_an",  {4'h0, bus.o_an}, 8'h0F);
    check("reset_seg", {1'b0, bus.o_seg}, 8'h7F);
    n_rst = 1'b1;

    run(DEAD);
    check("dead_before_first", {4'h0, bus.o_an}, 8'h0F);
    step();
    check("first_digit0", {4'h0, bus.o_an}, 8'h0E);

    run(2 * NUM * SLOT);

    bus.i_hex[0] = 7'h40;
    bus.i_hex[1] = 7'h79;
    bus.i_hex[2] = 7'h24;
    bus.i_hex[3] = 7'h30;
    run(NUM * SLOT + 10);

    wait_mid_on(1, "wait_digit1");
    bus.i_hex[1] = 7'h12;
    step();
    check("midslot_keeps_old", {1'b0, bus.o_seg}, 8'h79);
    run(NUM * SLOT + 10);

    wait_mid_on(2, "wait_digit2");
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_an",  {4'h0, bus.o_an}, 8'h0F);
    check("async_rst_seg", {1'b0, bus.o_seg}, 8'h7F);
    @(negedge clk);
    n_rst = 1'b1;
    run(DEAD + 1);
    check("restart_digit0", {4'h0, bus.o_an}, 8'h0E);
    run(NUM * SLOT);

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    bus.i_brightness = 4'd4;
    run(NUM * SLOT + SLOT);
    bus.i_brightness = 4'd15;
    run(NUM * SLOT + SLOT);
    bus.i_brightness = 4'd0;
    run(NUM * SLOT + SLOT);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
